// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle radix-2 multiply/divide unit with Start/Busy/Done handshake
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result_Hi,
  output logic [WIDTH-1:0] Result_Lo,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, FINISH} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] op_r;
  logic [WIDTH-1:0] a_raw, b_raw, m, hi, lo;
  logic sa, sb, is_div;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem, fix_hi, fix_lo;
  logic [WIDTH:0] sum, sh, diff;
  logic [2*WIDTH-1:0] step, prod;
  always_comb begin
    is_div = op_r[1];
    sa = op_r[0] & a_raw[WIDTH-1];
    sb = op_r[0] & b_raw[WIDTH-1];
    a_mag = sa ? -a_raw : a_raw;
    b_mag = sb ? -b_raw : b_raw;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    sh = {hi, lo[WIDTH-1]};
    diff = sh - {1'b0, m};
    // restoring divide: keep the shifted remainder when the subtract borrows
    step = is_div ? (diff[WIDTH] ? {sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1})
                  : {sum, lo[WIDTH-1:1]};
    prod = (sa ^ sb) ? -{hi, lo} : {hi, lo};
    quo = (sa ^ sb) ? -lo : lo;
    rem = sa ? -hi : hi;
    fix_hi = !is_div ? prod[2*WIDTH-1:WIDTH] : (b_raw == '0) ? a_raw : rem;
    fix_lo = !is_div ? prod[WIDTH-1:0] : (b_raw == '0) ? '1 : quo;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      Result_Hi <= '0;
      Result_Lo <= '0;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          op_r <= Op;
          a_raw <= A;
          b_raw <= B;
          Busy <= 1'b1;
          state <= PREP;
        end
        PREP: begin
          m <= is_div ? b_mag : a_mag;
          hi <= '0;
          lo <= is_div ? a_mag : b_mag;
          cnt <= '0;
          state <= CALC;
        end
        CALC: begin
          {hi, lo} <= step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          Result_Hi <= fix_hi;
          Result_Lo <= fix_lo;
          Busy <= 1'b0;
          Done <= 1'b1;
          state <= FINISH;
        end
        FINISH: begin
          Done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
